// File: rtl/i2s_pkg.sv
// i2s_pkg: shared FSM encoding and FIFO word field widths for the I2S bulk scheduler
package i2s_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int INDEX_WIDTH = 8;
  localparam int ID_WIDTH    = 5;
  localparam int HDR_WIDTH   = INDEX_WIDTH + ID_WIDTH;
endpackage

// File: rtl/i2s_rr_arbiter.sv
// i2s_rr_arbiter: one-hot round-robin pick of the first requester after the pointer
module i2s_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  // scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    grant = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) grant = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/i2s_bulk_scheduler.sv
// i2s_bulk_scheduler: round-robin drain of per-channel sample bulks into one FIFO (optional bulk_cnt via I2S_SCHED_CNT_EN)
module i2s_bulk_scheduler
  import i2s_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int BULK_OF_DATA    = 87,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int ID_BASE         = 0
) (
  input  logic                       bclk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req,
  output logic [NUM_CH-1:0]          rd_en,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] rd_data,
  input  logic                       fifo_bulk_space,
  output logic                       w_enable,
  output logic [FIFO_DATA_WIDTH-1:0] wdata,
  output logic [NUM_CH-1:0]          grant,
  output logic [NUM_CH-1:0]          done,
`ifdef I2S_SCHED_CNT_EN
  output logic [15:0]                bulk_cnt,
`endif
  output logic                       busy
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [1:0] state;
  logic [INDEX_WIDTH-1:0] cnt, idx_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [PW-1:0] ptr, gidx, pick_idx;
  logic [NUM_CH-1:0] pick;
  logic [SAMPLE_WIDTH-1:0] sample;

  i2s_rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(pick)
  );

  // binary index of the arbiter's one-hot pick
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign busy   = state != S_IDLE;
  assign done   = (state == S_DRAIN) ? grant : '0;
  assign sample = rd_data[gidx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  assign wdata  = w_enable ? ((FIFO_DATA_WIDTH'(idx_q) << (FIFO_DATA_WIDTH - INDEX_WIDTH))
                            | (FIFO_DATA_WIDTH'(id_q) << SAMPLE_WIDTH)
                            | FIFO_DATA_WIDTH'(sample)) : '0;

  // bulk FSM: arbitrate, stream BULK_OF_DATA reads, write each one a cycle later
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      id_q     <= '0;
      gidx     <= '0;
      ptr      <= PW'(NUM_CH - 1);
      rd_en    <= '0;
      grant    <= '0;
      w_enable <= 1'b0;
    end else begin
      w_enable <= |rd_en;
      idx_q    <= cnt;
      case (state)
        S_IDLE: state <= (|req && fifo_bulk_space) ? S_ARB : S_IDLE;
        S_ARB: begin
          grant <= pick;
          rd_en <= pick;
          gidx  <= pick_idx;
          id_q  <= ID_WIDTH'(ID_BASE + int'(pick_idx));
          cnt   <= '0;
          state <= |pick ? S_XFER : S_IDLE;
        end
        S_XFER: begin
          cnt <= cnt + 1'b1;
          if (cnt == INDEX_WIDTH'(BULK_OF_DATA - 1)) begin
            rd_en <= '0;
            state <= S_DRAIN;
          end
        end
        default: begin
          grant <= '0;
          ptr   <= gidx;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef I2S_SCHED_CNT_EN
  // completed-bulk counter, wraps naturally at 16 bits
  always_ff @(posedge bclk) begin
    if (!rst_n) bulk_cnt <= '0;
    else if (|done) bulk_cnt <= bulk_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_i2s_bulk_scheduler.sv
// tb_i2s_bulk_scheduler: scoreboard bench for i2s_bulk_scheduler (checks bulk_cnt when I2S_SCHED_CNT_EN is defined)
module tb_i2s_bulk_scheduler;
  localparam int N = 4, SW = 16, FW = 32, BULK = 87;
  logic bclk = 1'b0, rst_n = 1'b0, fifo_bulk_space = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] rd_en, grant, done;
  logic [N*SW-1:0] rd_data = '0;
  logic w_enable, busy;
  logic [FW-1:0] wdata;
`ifdef I2S_SCHED_CNT_EN
  logic [15:0] bulk_cnt;
`endif
  int cmp = 0, mis = 0, viol = 0, gseen = 0;
  int rcnt[N], rd_tot[N];
  logic [FW-1:0] wq[$];
  logic [N-1:0] dq[$], gq[$];
  logic [N-1:0] prev_g = '0, en_s = '0;

  i2s_bulk_scheduler dut (
    .bclk(bclk), .rst_n(rst_n), .req(req), .rd_en(rd_en), .rd_data(rd_data),
    .fifo_bulk_space(fifo_bulk_space), .w_enable(w_enable), .wdata(wdata),
    .grant(grant), .done(done),
`ifdef I2S_SCHED_CNT_EN
    .bulk_cnt(bulk_cnt),
`endif
    .busy(busy)
  );

  always #5 bclk = ~bclk;

  function automatic logic [SW-1:0] samp(input int ch, input int k);
    return SW'(ch * 32'h1111) ^ SW'(k * 32'h0203) ^ 16'h5A00;
  endfunction

  function automatic logic [FW-1:0] exp_word(input int ch, input int k);
    return {8'(k), 3'b000, 5'(ch), samp(ch, k)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_bulk(input int ch, input int nw, input bit with_done);
    gq.push_back(N'(1 << ch));
    for (int k = 0; k < nw; k++) wq.push_back(exp_word(ch, k));
    if (with_done) dq.push_back(N'(1 << ch));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 0);
    check({tag, "_w_enable"}, 64'(w_enable), 0);
    check({tag, "_wdata"}, 64'(wdata), 0);
    check({tag, "_grant"}, 64'(grant), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_busy"}, 64'(busy), 0);
  endtask

  task automatic wait_gseen(input int target, input string nm);
    bit ok = 0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge bclk);
      ok = gseen >= target;
    end
    check({nm, "_grant_timeout"}, 64'(ok), 1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge bclk);
      ok = wq.size() == 0 && dq.size() == 0 && gq.size() == 0 && !busy;
    end
    check({nm, "_idle_timeout"}, 64'(ok), 1);
  endtask

  task automatic wait_reads(input int ch, input int n, input string nm);
    int c = 0;
    for (int t = 0; t < 2000 && c < n; t++) begin
      @(negedge bclk);
      if (rd_en[ch]) c++;
    end
    check({nm, "_reads_timeout"}, 64'(c), 64'(n));
  endtask

  // responder: sample appears the cycle after its read strobe
  initial begin
    for (int i = 0; i < N; i++) rcnt[i] = 0;
    forever begin
      @(negedge bclk);
      en_s = rd_en;
      @(posedge bclk);
      #1;
      if (!rst_n) for (int i = 0; i < N; i++) rcnt[i] = 0;
      else for (int i = 0; i < N; i++)
        if (en_s[i]) begin
          rd_data[i*SW +: SW] = samp(i, rcnt[i]);
          rcnt[i] = (rcnt[i] == BULK - 1) ? 0 : rcnt[i] + 1;
        end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a write, done or new grant
  initial begin
    for (int i = 0; i < N; i++) rd_tot[i] = 0;
    forever begin
      @(negedge bclk);
      if (w_enable) begin
        if (wq.size() == 0) check("unexpected_write", 64'(wdata), 0);
        else check("wdata", 64'(wdata), 64'(wq.pop_front()));
      end
      if (done != 0) begin
        if (dq.size() == 0) check("unexpected_done", 64'(done), 0);
        else check("done", 64'(done), 64'(dq.pop_front()));
      end
      if (grant != 0 && prev_g == 0) begin
        gseen++;
        if (gq.size() == 0) check("unexpected_grant", 64'(grant), 0);
        else check("grant", 64'(grant), 64'(gq.pop_front()));
      end
      prev_g = grant;
      if ($countones(rd_en) > 1 || (rd_en != 0 && rd_en !== grant) || (grant != 0 && !$onehot(grant))) viol++;
      for (int i = 0; i < N; i++) if (rd_en[i]) rd_tot[i]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0[N];
    int lat, quiet;
    repeat (3) @(negedge bclk);
    chk_zero("reset");
    rst_n = 1'b1;
    fifo_bulk_space = 1'b1;
    @(negedge bclk);
    // all four requesting: ch0 first, then rotation wraps back to ch0
    push_bulk(0, BULK, 1); push_bulk(1, BULK, 1); push_bulk(2, BULK, 1);
    push_bulk(3, BULK, 1); push_bulk(0, BULK, 1);
    req = 4'b1111;
    wait_gseen(gseen + 5, "rr");
    req = '0;
    wait_idle("rr");
`ifdef I2S_SCHED_CNT_EN
    check("bulk_cnt_5", 64'(bulk_cnt), 5);
`endif
    // single channel 1 bulk
    for (int i = 0; i < N; i++) t0[i] = rd_tot[i];
    push_bulk(1, BULK, 1);
    req = 4'b0010;
    wait_gseen(gseen + 1, "single");
    req = '0;
    wait_idle("single");
    check("single_rd_en1_count", 64'(rd_tot[1] - t0[1]), BULK);
    check("single_rd_en_others", 64'((rd_tot[0] - t0[0]) + (rd_tot[2] - t0[2]) + (rd_tot[3] - t0[3])), 0);
    // request held off by missing FIFO space
    fifo_bulk_space = 1'b0;
    push_bulk(2, BULK, 1);
    req = 4'b0100;
    quiet = 0;
    repeat (20) begin
      @(negedge bclk);
      if (rd_en != 0 || busy) quiet++;
    end
    check("nospace_quiet", 64'(quiet), 0);
    fifo_bulk_space = 1'b1;
    lat = 0;
    for (int t = 0; t < 10 && rd_en == 0; t++) begin
      @(negedge bclk);
      lat++;
    end
    check("space_to_rd_en_latency", 64'(lat), 2);
    check("first_rd_en_ch2", 64'(rd_en), 64'(4'b0100));
    req = '0;
    @(negedge bclk);
    check("first_w_enable", 64'(w_enable), 1);
    wait_idle("nospace");
    // drop space and request mid-bulk: bulk still completes
    push_bulk(0, BULK, 1);
    req = 4'b0001;
    wait_reads(0, 41, "drop");
    fifo_bulk_space = 1'b0;
    req = '0;
    wait_idle("drop");
    fifo_bulk_space = 1'b1;
    // reset during the 31st read of a ch1 bulk: 30 words then abort
    gq.push_back(4'b0010);
    for (int k = 0; k < 30; k++) wq.push_back(exp_word(1, k));
    req = 4'b0010;
    wait_reads(1, 31, "abort");
    rst_n = 1'b0;
    req = '0;
    @(negedge bclk);
    chk_zero("abort");
    check("abort_words_left", 64'(wq.size()), 0);
    @(negedge bclk);
    rst_n = 1'b1;
    @(negedge bclk);
    push_bulk(3, BULK, 1);
    req = 4'b1000;
    wait_gseen(gseen + 1, "post_reset");
    req = '0;
    wait_idle("post_reset");
`ifdef I2S_SCHED_CNT_EN
    check("bulk_cnt_after_reset", 64'(bulk_cnt), 1);
`endif
    check("onehot_violations", 64'(viol), 0);
    check("queues_empty", 64'(wq.size() + dq.size() + gq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
